uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive half of the on-chip UART, the counterpart of the UART transmitter. It oversamples an asynchronous 8N1 line (1 start bit, 8 data bits LSB first, 1 stop bit) at the system clock rate and presents each received byte on a ready/valid interface. It validates the start bit and checks the stop bit, reporting framing errors and overruns as one-cycle pulses. It sits between the board RX pin and the CPU's memory-mapped UART control/data registers.

## Interface
- CLOCK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits/s.
- Derived `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (1085 at defaults), in cycles per bit.
- Derived `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2` (542 at defaults).
- Counter width is `$clog2(SYMBOL_EDGE_TIME)`.

Ports:
- clk  in  1: system clock; all logic on posedge.
- reset_n  in  1: synchronous, active-low reset.
- serial_in  in  1: asynchronous RX line; idles high.
- data_out  out  8: received byte; stable while data_out_valid=1.
- data_out_valid  out  1: byte available; held until accepted.
- data_out_ready  in  1: consumer accepts when valid & ready at posedge.
- framing_error  out  1: one-cycle pulse; stop bit sampled low.
- overrun  out  1: one-cycle pulse; a good byte was dropped because the buffer was still full.

## Operation
- Synchronizer: serial_in passes through 2 flops to give `rx_s`, which is reset to 1. All decisions use `rx_s`.
- FSM states and transitions:
  - IDLE: on `rx_s==0`, clear the counter and go to START.
  - START: at counter==SAMPLE_TIME-1, sample `rx_s`.
    - If 1, it was a glitch: go to IDLE, no output.
    - If 0, clear the counter, clear bit index, go to DATA.
  - DATA: at counter==SYMBOL_EDGE_TIME-1, sample `rx_s` into shift bit [index]; data is LSB first.
    - Clear the counter. After index 7, go to STOP.
  - STOP: at counter==SYMBOL_EDGE_TIME-1, sample `rx_s`.
    - If 1: deliver the byte (see output buffer below), go to IDLE.
    - If 0: pulse framing_error, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s==1`, then go to IDLE. This stops a held-low line (break) from retriggering.
- Output buffer: one byte.
  - If delivering while `data_out_valid & ~data_out_ready`, keep the old byte and pulse overrun.
  - Otherwise load data_out and set data_out_valid.
- data_out_valid clears on the handshake cycle.
- A simultaneous handshake and delivery is legal: the new byte loads, valid stays 1, and there is no overrun.
- The counter only runs in START/DATA/STOP. It never wraps past SYMBOL_EDGE_TIME-1.

## Timing
- Reset values:
  - data_out=0, data_out_valid=0, framing_error=0, overrun=0.
  - FSM=IDLE, counter=0, synchronizer flops=1.
- Reset asserted mid-frame returns to IDLE next cycle and drops the partial byte and any buffered byte.
- Latency from the serial_in falling edge to entering START is 3 cycles (2 sync flops + 1 detect).
- Sample points, counted from the START entry cycle:
  - Start check: cycle SAMPLE_TIME-1.
  - Data bit k: cycle SAMPLE_TIME + (k+1)·SYMBOL_EDGE_TIME - 1.
  - Stop bit: k=8 in the same formula.
- data_out_valid and the error pulses rise 1 cycle after the stop sample.
- Back-to-back frames are supported: IDLE is re-entered at mid-stop-bit, so the next start edge is never missed.
- Tolerates about ±4% baud mismatch.

## Structure
- Shared `uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, WAIT_IDLE);
  - frame constants: DATA_BITS=8, stop/start levels;
  - shared helper math for SYMBOL_EDGE_TIME / SAMPLE_TIME, also used by the transmitter.
- One sub-module `sync_2ff` (parameterized reset value, default 1) for the RX synchronizer. Everything else stays inline.

## Test plan
All scenarios use CLOCK_FREQ=1000 and BAUD_RATE=100, giving SYMBOL_EDGE_TIME=10 and SAMPLE_TIME=5.
- Send 0xA5, ready held 1:
  - data_out=0xA5 with valid for exactly 1 cycle;
  - valid rises 1 cycle after the stop sample (cycle 94 after START entry);
  - no error pulses.
- Send 0x3C then 0xFF back-to-back with ready=0: 0x3C remains on data_out, overrun pulses once, and 0x3C is accepted when ready is later raised.
- Drive a 3-cycle low glitch on idle line: no valid and no error; the FSM returns to IDLE after the start check.
- Send 0x55 with the stop bit forced low, then hold the line low for 50 cycles:
  - framing_error pulses once; no valid;
  - no new frame starts until the line returns high.
- Assert reset_n=0 for 1 cycle during data bit 4 of 0x81, then send 0x7E: only 0x7E is delivered, and all outputs read 0 during reset.
- Deliver a byte on the same cycle a handshake consumes the previous one: the new byte is presented, valid stays high, and there is no overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, 8N1 frame
// constants and baud timing helpers (also used by the transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Clock cycles per bit period.
    function automatic int symbol_edge_time(
        input int clock_freq,
        input int baud_rate
    );
        return clock_freq / baud_rate;
    endfunction

    // Cycles from a bit edge to its centre.
    function automatic int sample_time(
        input int clock_freq,
        input int baud_rate
    );
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Ready/valid byte channel out of the UART receiver.
// Ports: data_out, data_out_valid (producer), data_out_ready (consumer).
interface uart_receiver_if;

    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, reset_n (sync, active low), i_d (async in), o_q (synced out).
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled RX line to a one-byte ready/valid buffer.
// Ports: clk, reset_n (sync, active low), serial_in (async RX line),
//        rx_if (data_out/valid/ready), framing_error, overrun (1-cycle pulses).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            serial_in,
    uart_receiver_if.master rx_if,
    output logic            framing_error,
    output logic            overrun
);

    localparam int SYMBOL_EDGE_TIME =
        symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME =
        sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [2:0]    IDX_LAST    = 3'(DATA_BITS - 1);

    logic        w_rx_s;

    uart_state_e r_state;
    uart_state_e w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        w_deliver;
    logic        w_ferr_next;

    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        r_ovr;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .i_d    (serial_in),
        .o_q    (w_rx_s)
    );

    // Start check lands mid start bit; every later sample is one full
    // bit period on, so all data/stop samples sit near bit centres.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_deliver    = 1'b0;
        w_ferr_next  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rx_s == START_LEVEL) begin
                    w_cnt_next   = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == SAMPLE_LAST) begin
                    if (w_rx_s != START_LEVEL) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                        w_state_next = S_DATA;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == SYMBOL_LAST) begin
                    w_shift_next[r_idx] = w_rx_s;
                    w_cnt_next          = '0;
                    w_idx_next          = r_idx + 3'd1;
                    if (r_idx == IDX_LAST) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == SYMBOL_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s == STOP_LEVEL) begin
                        w_deliver    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                // A held-low break must not look like a new start bit.
                if (w_rx_s == IDLE_LEVEL) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_ferr  <= w_ferr_next;
            r_ovr   <= 1'b0;
            // A consumer taking the old byte this cycle frees the slot,
            // so a coincident delivery loads instead of overrunning.
            if (w_deliver) begin
                if (r_valid && !rx_if.data_out_ready) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && rx_if.data_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.data_out       = r_data;
    assign rx_if.data_out_valid = r_valid;
    assign framing_error        = r_ferr;
    assign overrun              = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 10 cycles per bit.
// Drives 8N1 frames on serial_in and checks the ready/valid side.
module tb_uart_receiver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic serial_in = 1'b1;
    logic framing_error;
    logic overrun;

    uart_receiver_if rx_if ();

    uart_receiver #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .rx_if        (rx_if),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rise_cnt = 0;
    int hi_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_rise = 0;
    logic prev_valid = 1'b0;
    logic [7:0] acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_if.data_out_valid) begin
                hi_cnt++;
                if (!prev_valid) begin
                    rise_cnt++;
                    last_rise = cyc;
                end
                if (rx_if.data_out_ready)
                    acc_q.push_back(rx_if.data_out);
            end
            if (framing_error) fe_cnt++;
            if (overrun) ov_cnt++;
            prev_valid = rx_if.data_out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(10);
        end
        serial_in = stop;
        tick(10);
        serial_in = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        serial_in = 1'b1;
        rx_if.data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_if.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00", rx_if.data_out);
        end
        checks++;
        if (rx_if.data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", rx_if.data_out_valid);
        end
        checks++;
        if (framing_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ferr got %b want 0", framing_error);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovr got %b want 0", overrun);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(5);
    endtask

    task automatic test_single();
        int r0, h0, f0, o0, a0, t0;
        rx_if.data_out_ready = 1'b1;
        r0 = rise_cnt; h0 = hi_cnt; f0 = fe_cnt;
        o0 = ov_cnt; a0 = acc_q.size(); t0 = cyc;
        drive_frame(8'hA5, 1'b1);
        tick(10);
        checks++;
        if (rise_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL single_rises got %0d want 1", rise_cnt - r0);
        end
        checks++;
        if (hi_cnt - h0 !== 1) begin
            errors++;
            $display("FAIL single_valid_len got %0d want 1", hi_cnt - h0);
        end
        // 3 cycles to START entry, stop sample at 94, valid 1 later.
        checks++;
        if (last_rise - t0 !== 98) begin
            errors++;
            $display("FAIL single_latency got %0d want 98", last_rise - t0);
        end
        checks++;
        if (acc_q.size() - a0 !== 1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", acc_q.size() - a0);
        end
        checks++;
        if (acc_q[acc_q.size() - 1] !== 8'hA5) begin
            errors++;
            $display("FAIL single_data got %h want a5", acc_q[acc_q.size() - 1]);
        end
        checks++;
        if ((fe_cnt - f0) + (ov_cnt - o0) !== 0) begin
            errors++;
            $display("FAIL single_errs got %0d want 0", (fe_cnt - f0) + (ov_cnt - o0));
        end
    endtask

    task automatic test_overrun();
        int r0, f0, o0, a0;
        rx_if.data_out_ready = 1'b0;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; a0 = acc_q.size();
        drive_frame(8'h3C, 1'b1);
        drive_frame(8'hFF, 1'b1);
        tick(10);
        checks++;
        if (rx_if.data_out !== 8'h3C) begin
            errors++;
            $display("FAIL ovr_data got %h want 3c", rx_if.data_out);
        end
        checks++;
        if (rx_if.data_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovr_valid got %b want 1", rx_if.data_out_valid);
        end
        checks++;
        if (ov_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL ovr_pulses got %0d want 1", ov_cnt - o0);
        end
        checks++;
        if ((fe_cnt - f0) !== 0 || (rise_cnt - r0) !== 1) begin
            errors++;
            $display("FAIL ovr_misc got fe=%0d rise=%0d want fe=0 rise=1", fe_cnt - f0, rise_cnt - r0);
        end
        rx_if.data_out_ready = 1'b1;
        tick(1);
        rx_if.data_out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h3C) begin
            errors++;
            $display("FAIL ovr_accept got n=%0d last=%h want n=1 last=3c", acc_q.size() - a0, acc_q[acc_q.size() - 1]);
        end
        checks++;
        if (rx_if.data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain got %b want 0", rx_if.data_out_valid);
        end
        tick(2);
    endtask

    task automatic test_glitch();
        int r0, f0, a0;
        rx_if.data_out_ready = 1'b1;
        r0 = rise_cnt; f0 = fe_cnt; a0 = acc_q.size();
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(20);
        checks++;
        if (rise_cnt - r0 !== 0 || fe_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL glitch_quiet got rise=%0d fe=%0d want 0 0", rise_cnt - r0, fe_cnt - f0);
        end
        drive_frame(8'h96, 1'b1);
        tick(10);
        checks++;
        if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h96) begin
            errors++;
            $display("FAIL glitch_recover got n=%0d last=%h want n=1 last=96", acc_q.size() - a0, acc_q[acc_q.size() - 1]);
        end
    endtask

    task automatic test_framing();
        int r0, f0, o0, a0;
        rx_if.data_out_ready = 1'b1;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; a0 = acc_q.size();
        drive_frame(8'h55, 1'b0);
        serial_in = 1'b0;
        tick(50);
        serial_in = 1'b1;
        tick(150);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL frame_ferr got %0d want 1", fe_cnt - f0);
        end
        checks++;
        if (rise_cnt - r0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL frame_novalid got rise=%0d ov=%0d want 0 0", rise_cnt - r0, ov_cnt - o0);
        end
        drive_frame(8'h5A, 1'b1);
        tick(10);
        checks++;
        if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h5A) begin
            errors++;
            $display("FAIL frame_recover got n=%0d last=%h want n=1 last=5a", acc_q.size() - a0, acc_q[acc_q.size() - 1]);
        end
        checks++;
        if (fe_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL frame_ferr_after got %0d want 1", fe_cnt - f0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int r0, f0, o0, a0;
        b = 8'h81;
        rx_if.data_out_ready = 1'b0;
        drive_frame(8'h11, 1'b1);
        tick(5);
        checks++;
        if (rx_if.data_out_valid !== 1'b1 || rx_if.data_out !== 8'h11) begin
            errors++;
            $display("FAIL rst_buffered got v=%b d=%h want v=1 d=11", rx_if.data_out_valid, rx_if.data_out);
        end
        serial_in = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            serial_in = b[i];
            tick(10);
        end
        serial_in = b[4];
        tick(5);
        reset_n = 1'b0;
        serial_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_if.data_out !== 8'h00 || rx_if.data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out got v=%b d=%h want v=0 d=00", rx_if.data_out_valid, rx_if.data_out);
        end
        checks++;
        if (framing_error !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pulses got fe=%b ov=%b want 0 0", framing_error, overrun);
        end
        reset_n = 1'b1;
        tick(20);
        rx_if.data_out_ready = 1'b1;
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt; a0 = acc_q.size();
        drive_frame(8'h7E, 1'b1);
        tick(10);
        checks++;
        if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h7E) begin
            errors++;
            $display("FAIL rst_next got n=%0d last=%h want n=1 last=7e", acc_q.size() - a0, acc_q[acc_q.size() - 1]);
        end
        checks++;
        if (rise_cnt - r0 !== 1 || fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL rst_next_misc got rise=%0d fe=%0d ov=%0d want 1 0 0", rise_cnt - r0, fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int r0, o0, a0;
        rx_if.data_out_ready = 1'b0;
        r0 = rise_cnt; o0 = ov_cnt; a0 = acc_q.size();
        drive_frame(8'h3C, 1'b1);
        tick(5);
        // Ready is high only across the edge where C3 is delivered.
        fork
            drive_frame(8'hC3, 1'b1);
            begin
                tick(97);
                rx_if.data_out_ready = 1'b1;
                tick(1);
                rx_if.data_out_ready = 1'b0;
            end
        join
        checks++;
        if (rx_if.data_out !== 8'hC3 || rx_if.data_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_new got v=%b d=%h want v=1 d=c3", rx_if.data_out_valid, rx_if.data_out);
        end
        checks++;
        if (ov_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL b2b_ovr got %0d want 0", ov_cnt - o0);
        end
        checks++;
        if (acc_q.size() - a0 !== 1 || acc_q[acc_q.size() - 1] !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_old got n=%0d last=%h want n=1 last=3c", acc_q.size() - a0, acc_q[acc_q.size() - 1]);
        end
        checks++;
        if (rise_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL b2b_held got rises=%0d want 1", rise_cnt - r0);
        end
        rx_if.data_out_ready = 1'b1;
        tick(2);
        rx_if.data_out_ready = 1'b0;
        checks++;
        if (acc_q.size() - a0 !== 2 || acc_q[acc_q.size() - 1] !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_drain got n=%0d last=%h want n=2 last=c3", acc_q.size() - a0, acc_q[acc_q.size() - 1]);
        end
        checks++;
        if (rx_if.data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got %b want 0", rx_if.data_out_valid);
        end
    endtask

    initial begin
        rx_if.data_out_ready = 1'b0;
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
